// File: rtl/alarm_annunciator_if.sv
// Panel-side bundle for alarm_annunciator: evaluator level + operator ack in,
// lamp / buzzer / status / event count out.
interface alarm_annunciator_if;
   logic       L;
   logic       ack;
   logic       lamp;
   logic       buzzer;
   logic       active;
   logic       escalate;
   logic [7:0] alarm_count;

   // Driver side (evaluator / panel / testbench)
   modport master (
      output L, ack,
      input  lamp, buzzer, active, escalate, alarm_count
   );

   // Annunciator side
   modport slave (
      input  L, ack,
      output lamp, buzzer, active, escalate, alarm_count
   );
endinterface

// File: rtl/alarm_annunciator.sv
// alarm_annunciator: qualifies the evaluator alarm level over consecutive
// cycles, latches the alarm (buzzer + blinking lamp) until acknowledged,
// and counts alarm entries (saturating).
// Optional macro ALARM_TIMEOUT_EN: adds the unacknowledged-alarm timeout
// counter driving escalate; without it escalate is tied low.
module alarm_annunciator #(
   parameter int unsigned CNT_W          = 8,
   parameter int unsigned QUAL_CYCLES    = 4,
   parameter int unsigned BLINK_HALF     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   alarm_annunciator_if.slave sif
);

   localparam int unsigned COUNT_W = 8;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_QUAL     = 2'd1;
   localparam logic [1:0] S_ALARM    = 2'd2;
   localparam logic [1:0] S_SILENCED = 2'd3;

   localparam logic [CNT_W-1:0]   QUAL_LAST  = CNT_W'(QUAL_CYCLES);
   localparam logic [CNT_W-1:0]   BLINK_LAST = CNT_W'(BLINK_HALF);
   localparam logic [COUNT_W-1:0] COUNT_SAT  = '1;

   // Reject cycle parameters that cannot be represented or are zero
   if (QUAL_CYCLES == 0 || BLINK_HALF == 0 || QUAL_CYCLES > CNT_MAX ||
       BLINK_HALF > CNT_MAX || TIMEOUT_CYCLES > CNT_MAX) begin : g_bad_params
      $error("alarm_annunciator: cycle parameter out of range");
   end

   logic [1:0]         r_state,  w_state_n;
   logic [CNT_W-1:0]   r_qcnt,   w_qcnt_n;
   logic [CNT_W-1:0]   r_blink,  w_blink_n;
   logic [COUNT_W-1:0] r_count,  w_count_n;
   logic               r_lamp,   w_lamp_n;
   logic               r_buzzer, w_buzzer_n;
   logic               r_active, w_active_n;
   logic               w_enter_alarm;

   // Next-state logic and qualify counter
   always_comb begin
      w_state_n = r_state;
      w_qcnt_n  = r_qcnt;
      case (r_state)
         S_IDLE: begin
            if (sif.L) begin
               if (QUAL_CYCLES == 1) begin
                  w_state_n = S_ALARM;
               end else begin
                  w_state_n = S_QUAL;
                  w_qcnt_n  = CNT_W'(1);
               end
            end
         end
         S_QUAL: begin
            if (!sif.L) begin
               w_state_n = S_IDLE;
               w_qcnt_n  = '0;
            end else if (r_qcnt + CNT_W'(1) == QUAL_LAST) begin
               w_state_n = S_ALARM;
               w_qcnt_n  = '0;
            end else begin
               w_qcnt_n  = r_qcnt + CNT_W'(1);
            end
         end
         S_ALARM: begin
            if (sif.ack) begin
               w_state_n = sif.L ? S_SILENCED : S_IDLE;
            end
         end
         S_SILENCED: begin
            if (!sif.L) begin
               w_state_n = S_IDLE;
            end
         end
         default: begin
            w_state_n = S_IDLE;
            w_qcnt_n  = '0;
         end
      endcase
   end

   // Outputs decoded from the next state: blink, buzzer, active, event count
   always_comb begin
      w_enter_alarm = (w_state_n == S_ALARM) && (r_state != S_ALARM);
      w_blink_n     = '0;
      w_lamp_n      = 1'b0;
      w_buzzer_n    = (w_state_n == S_ALARM);
      w_active_n    = (w_state_n != S_IDLE);
      w_count_n     = r_count;
      if (w_enter_alarm) begin
         w_lamp_n = 1'b1;
         if (r_count != COUNT_SAT) begin
            w_count_n = r_count + COUNT_W'(1);
         end
      end else if (w_state_n == S_ALARM) begin
         if (r_blink + CNT_W'(1) == BLINK_LAST) begin
            w_lamp_n = ~r_lamp;
         end else begin
            w_blink_n = r_blink + CNT_W'(1);
            w_lamp_n  = r_lamp;
         end
      end else if (w_state_n == S_SILENCED) begin
         w_lamp_n = 1'b1;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_qcnt   <= '0;
         r_blink  <= '0;
         r_count  <= '0;
         r_lamp   <= 1'b0;
         r_buzzer <= 1'b0;
         r_active <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_qcnt   <= w_qcnt_n;
         r_blink  <= w_blink_n;
         r_count  <= w_count_n;
         r_lamp   <= w_lamp_n;
         r_buzzer <= w_buzzer_n;
         r_active <= w_active_n;
      end
   end

   assign sif.lamp        = r_lamp;
   assign sif.buzzer      = r_buzzer;
   assign sif.active      = r_active;
   assign sif.alarm_count = r_count;

`ifdef ALARM_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] r_tcnt, w_tcnt_n;
   logic             r_escalate, w_escalate_n;

   // Timeout counter: runs while ALARM persists, holds at the limit
   always_comb begin
      w_tcnt_n = '0;
      if ((w_state_n == S_ALARM) && !w_enter_alarm) begin
         w_tcnt_n = (r_tcnt == TOUT_LAST) ? r_tcnt : r_tcnt + CNT_W'(1);
      end
      w_escalate_n = (w_state_n == S_ALARM) && (w_tcnt_n == TOUT_LAST);
   end

   // Timeout registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tcnt     <= '0;
         r_escalate <= 1'b0;
      end else begin
         r_tcnt     <= w_tcnt_n;
         r_escalate <= w_escalate_n;
      end
   end

   assign sif.escalate = r_escalate;
`else
   assign sif.escalate = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_annunciator.sv
// Scoreboard bench for alarm_annunciator: directed scenarios plus random
// level/ack traffic, checked against a behavioural model.
module tb_alarm_annunciator;

   localparam int unsigned QUAL_CYCLES    = 4;
   localparam int unsigned BLINK_HALF     = 8;
   localparam int unsigned TIMEOUT_CYCLES = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;

   alarm_annunciator_if ifc();

   alarm_annunciator #(
      .CNT_W          (8),
      .QUAL_CYCLES    (QUAL_CYCLES),
      .BLINK_HALF     (BLINK_HALF),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .sif (ifc.slave)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       lamp;
      logic       buzzer;
      logic       active;
      logic       escalate;
      logic [7:0] count;
   } exp_t;

   typedef enum int {M_IDLE, M_QUAL, M_ALARM, M_SIL} mode_t;

   exp_t  sb_q[$];
   int    checks   = 0;
   int    failures = 0;

   // Behavioural model: mode, length of the current high run of L,
   // cycles spent in the current alarm, number of alarms seen.
   mode_t m_mode  = M_IDLE;
   int    m_run   = 0;
   int    m_since = 0;
   int    m_count = 0;

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_run   = 0;
      m_since = 0;
      m_count = 0;
   endtask

   task automatic model_edge(input logic l, input logic a);
      case (m_mode)
         M_IDLE, M_QUAL: begin
            if (l) begin
               m_run = m_run + 1;
               if (m_run >= int'(QUAL_CYCLES)) begin
                  m_mode  = M_ALARM;
                  m_run   = 0;
                  m_since = 0;
                  if (m_count < 255) m_count = m_count + 1;
               end else begin
                  m_mode = M_QUAL;
               end
            end else begin
               m_run  = 0;
               m_mode = M_IDLE;
            end
         end
         M_ALARM: begin
            if (a) m_mode = l ? M_SIL : M_IDLE;
            else   m_since = m_since + 1;
         end
         M_SIL: begin
            if (!l) m_mode = M_IDLE;
         end
         default: m_mode = M_IDLE;
      endcase
   endtask

   function automatic exp_t model_outputs();
      exp_t e;
      e.buzzer = (m_mode == M_ALARM);
      e.active = (m_mode != M_IDLE);
      if (m_mode == M_ALARM) e.lamp = ((m_since / int'(BLINK_HALF)) % 2) == 0;
      else                   e.lamp = (m_mode == M_SIL);
`ifdef ALARM_TIMEOUT_EN
      e.escalate = (m_mode == M_ALARM) && (m_since >= int'(TIMEOUT_CYCLES));
`else
      e.escalate = 1'b0;
`endif
      e.count = 8'(m_count);
      return e;
   endfunction

   task automatic check_val(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus and queue the model's response to it
   task automatic step(input logic l, input logic a);
      @(negedge clk);
      ifc.L   = l;
      ifc.ack = a;
      model_edge(l, a);
      sb_q.push_back(model_outputs());
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_lamp"},   int'(ifc.lamp),        0);
      check_val({tag, "_buzzer"}, int'(ifc.buzzer),      0);
      check_val({tag, "_active"}, int'(ifc.active),      0);
      check_val({tag, "_esc"},    int'(ifc.escalate),    0);
      check_val({tag, "_count"},  int'(ifc.alarm_count), 0);
   endtask

   // Asynchronous reset asserted between edges, checked before the next edge
   task automatic mid_reset(input string tag);
      @(posedge clk);
      #3;
      rst     = 1'b1;
      ifc.L   = 1'b0;
      ifc.ack = 1'b0;
      #1;
      check_all_zero(tag);
      sb_q.delete();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: compare every registered output update against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("lamp",     int'(ifc.lamp),        int'(e.lamp));
            check_val("buzzer",   int'(ifc.buzzer),      int'(e.buzzer));
            check_val("active",   int'(ifc.active),      int'(e.active));
            check_val("escalate", int'(ifc.escalate),    int'(e.escalate));
            check_val("count",    int'(ifc.alarm_count), int'(e.count));
         end
      end
   end

   initial begin
      ifc.L   = 1'b0;
      ifc.ack = 1'b0;
      #2;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Short high run never qualifies
      repeat (3) step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);

      // Raise, blink for a while, drop L without ack, then ack to idle
      repeat (4)  step(1'b1, 1'b0);
      repeat (20) step(1'b1, 1'b0);
      repeat (20) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      repeat (3)  step(1'b0, 1'b0);

      // Silence with L high, extra ack ignored, clear, re-raise
      repeat (6) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      repeat (3) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      repeat (2) step(1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0);
      repeat (5) step(1'b1, 1'b0);

      // Async reset in the middle of an alarm
      mid_reset("midrst");

      // Ack held throughout qualification: one buzzer cycle, then silenced
      repeat (6) step(1'b1, 1'b1);
      repeat (2) step(1'b0, 1'b0);

      // Unacknowledged alarm runs past the timeout, then ack
      repeat (4)  step(1'b1, 1'b0);
      repeat (70) step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      repeat (2)  step(1'b0, 1'b0);

      // Event count saturation
      for (int i = 0; i < 260; i++) begin
         repeat (4) step(1'b1, 1'b0);
         step(1'b0, 1'b1);
         step(1'b0, 1'b0);
      end
      mid_reset("postsat");

      // Random level runs with sparse acks and occasional resets
      for (int s = 0; s < 400; s++) begin
         int   len;
         logic lv;
         len = int'($urandom_range(1, 12));
         lv  = ($urandom_range(0, 3) != 0);
         for (int c = 0; c < len; c++) begin
            step(lv, ($urandom_range(0, 7) == 0));
         end
         if ($urandom_range(0, 59) == 0) mid_reset("rndrst");
      end

      step(1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      check_val("sb_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
